ppu_stream: RTL

- Parametrised post-processing unit for the systolic-array accumulator stream. Generalises the fixed 16-lane PPU datapath.
- Per lane and per row: runtime-loadable scale and bias, optional ReLU, round-half-away-from-zero, symmetric saturation to OUT_W.
- Adds valid/ready flow control with backpressure and a row/tile sequencer with matrix-done signalling. Sits between accumulator drain and the quantize/softmax stages.

---
 rtl/ppu_stream.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/ppu_stream.sv
// rtl/ppu_stream.sv - accumulator post-processing stream: scale, bias, ReLU, round, saturate, row/tile sequencing
// Optional per-tile max |output| tracking is built when PPU_TILE_MAXABS_EN is defined.
module ppu_stream #(
    parameter int LANES     = 16,
    parameter int ACC_W     = 24,
    parameter int COEF_W    = 16,
    parameter int FRAC      = 10,
    parameter int OUT_W     = 18,
    parameter int ROWS      = 16,
    parameter int NUM_TILES = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic                       i_relu_en,
    input  logic                       i_cfg_we,
    input  logic                       i_cfg_sel,
    input  logic [$clog2(ROWS)-1:0]    i_cfg_addr,
    input  logic [LANES*COEF_W-1:0]    i_cfg_data,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [LANES*ACC_W-1:0]     i_acc_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [LANES*OUT_W-1:0]     o_data,
    output logic                       o_last,
    output logic                       o_done,
    output logic [OUT_W-2:0]           o_tile_maxabs,
    output logic                       o_tile_maxabs_valid
);

    localparam int RW     = $clog2(ROWS);
    localparam int TW     = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int PROD_W = ACC_W + COEF_W;
    localparam int SUM_W  = PROD_W + 1;
    localparam int RND_W  = SUM_W - FRAC + 1;

    localparam logic [RW-1:0]    ROW_LAST  = RW'(ROWS - 1);
    localparam logic [TW-1:0]    TILE_LAST = TW'(NUM_TILES - 1);
    localparam logic [RND_W-1:0] SAT_MAX   = RND_W'({(OUT_W-1){1'b1}});

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state;
    logic [RW-1:0]           row_cnt;
    logic [TW-1:0]           tile_cnt;
    logic                    relu_q;

    logic [LANES*COEF_W-1:0] scale_mem [ROWS];
    logic [LANES*COEF_W-1:0] bias_mem  [ROWS];
    logic [LANES*COEF_W-1:0] scale_rd;
    logic [LANES*COEF_W-1:0] bias_rd;

    logic                    adv;
    logic                    accept;

    logic                    s1_valid;
    logic [RW-1:0]           s1_row;
    logic signed [SUM_W-1:0] s1_sum [LANES];
    logic signed [SUM_W-1:0] sum_c  [LANES];

    logic                    s2_valid;
    logic                    s2_last;
    logic [LANES*OUT_W-1:0]  s2_data;
    logic [LANES*OUT_W-1:0]  out_vec;

    // Two-entry pipeline moves as a whole whenever the output slot can drain.
    assign adv     = !s2_valid || i_ready;
    assign o_ready = adv && (state == RUN);
    assign accept  = i_valid && o_ready;

    assign o_valid = s2_valid;
    assign o_data  = s2_data;
    assign o_last  = s2_last;

    assign scale_rd = scale_mem[row_cnt];
    assign bias_rd  = bias_mem[row_cnt];

    // Coefficient RAMs keep their contents across reset.
    always_ff @(posedge i_clk) begin
        if (i_cfg_we && (state == IDLE)) begin
            if (i_cfg_sel) begin
                bias_mem[i_cfg_addr] <= i_cfg_data;
            end else begin
                scale_mem[i_cfg_addr] <= i_cfg_data;
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [COEF_W-1:0] sc;
        logic signed [COEF_W-1:0] bi;
        logic signed [ACC_W-1:0]  ac;
        logic signed [PROD_W-1:0] prod;
        logic signed [SUM_W-1:0]  rs;
        logic                     neg;
        logic [SUM_W-1:0]         mag;
        logic [RND_W-1:0]         rnd;
        logic [OUT_W-2:0]         sat;
        logic [OUT_W-1:0]         pos;

        assign sc       = scale_rd[l*COEF_W +: COEF_W];
        assign bi       = bias_rd[l*COEF_W +: COEF_W];
        assign ac       = i_acc_data[l*ACC_W +: ACC_W];
        assign prod     = sc * ac;
        assign sum_c[l] = SUM_W'(prod) + SUM_W'(bi);

        // Work on the magnitude so rounding is half-away-from-zero for both signs.
        assign rs  = (relu_q && s1_sum[l][SUM_W-1]) ? '0 : s1_sum[l];
        assign neg = rs[SUM_W-1];
        assign mag = neg ? -rs : rs;
        assign rnd = {1'b0, mag[SUM_W-1:FRAC]} + RND_W'(mag[FRAC-1]);
        assign sat = (rnd > SAT_MAX) ? '1 : rnd[OUT_W-2:0];
        assign pos = {1'b0, sat};
        assign out_vec[l*OUT_W +: OUT_W] = neg ? -pos : pos;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid <= 1'b0;
            s1_row   <= '0;
            for (int l = 0; l < LANES; l++) begin
                s1_sum[l] <= '0;
            end
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_data  <= '0;
        end else if (adv) begin
            s1_valid <= accept;
            if (accept) begin
                s1_sum <= sum_c;
                s1_row <= row_cnt;
            end
            s2_valid <= s1_valid;
            s2_last  <= s1_valid && (s1_row == ROW_LAST);
            if (s1_valid) begin
                s2_data <= out_vec;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            row_cnt  <= '0;
            tile_cnt <= '0;
            relu_q   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        relu_q   <= i_relu_en;
                        row_cnt  <= '0;
                        tile_cnt <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (row_cnt == ROW_LAST) begin
                            row_cnt <= '0;
                            if (tile_cnt == TILE_LAST) begin
                                tile_cnt <= '0;
                                state    <= DRAIN;
                            end else begin
                                tile_cnt <= tile_cnt + 1'b1;
                            end
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Finish on the handshake of the final beat so o_done lands one cycle after it.
                    if ((s2_valid && i_ready && !s1_valid) || (!s1_valid && !s2_valid)) begin
                        o_done <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PPU_TILE_MAXABS_EN
    logic [OUT_W-2:0] lane_abs [LANES];
    logic [OUT_W-2:0] run_max;
    logic [OUT_W-2:0] beat_max;
    logic [OUT_W-2:0] new_max;
    logic             out_hs;

    for (genvar l = 0; l < LANES; l++) begin : g_abs
        logic [OUT_W-1:0] v;
        logic [OUT_W-1:0] a;
        assign v           = s2_data[l*OUT_W +: OUT_W];
        assign a           = v[OUT_W-1] ? -v : v;
        assign lane_abs[l] = a[OUT_W-2:0];
    end

    always_comb begin
        beat_max = '0;
        for (int l = 0; l < LANES; l++) begin
            if (lane_abs[l] > beat_max) begin
                beat_max = lane_abs[l];
            end
        end
        new_max = (beat_max > run_max) ? beat_max : run_max;
    end

    assign out_hs              = s2_valid && i_ready;
    assign o_tile_maxabs_valid = out_hs && s2_last;
    assign o_tile_maxabs       = (out_hs && s2_last) ? new_max : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            run_max <= '0;
        end else if (out_hs) begin
            run_max <= s2_last ? '0 : new_max;
        end
    end
`else
    assign o_tile_maxabs       = '0;
    assign o_tile_maxabs_valid = 1'b0;
`endif

endmodule
